dmem_port_ctrl: RTL
===================

# dmem_port_ctrl

Sequencer and arbiter for the data port of the RV32I `memory` block (ports `address`, `data_in`, `str`, `ld`, `byte_masking`, `data_out`). It shares that single data port between two requesters:

- the core load/store unit (LSU), and
- a word-only debug/loader port (DBG).

It converts RV32I load/store width codes into byte masks and lane-shifted write data, and aligns and sign- or zero-extends load results. The instruction port of `memory` is not touched by this block.

## Interface
Parameters:
- `ADDR_W`, 12, memory word-address width; requester byte addresses are `ADDR_W+2` bits.
- `MAX_STREAK`, 4, consecutive LSU grants allowed while DBG is waiting (guard build only); legal range 1–15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ls_req`  in  1  LSU request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ls_addr`  in  ADDR_W+2  byte address.
- `ls_wdata`  in  32  store data, right-aligned.
- `ls_gnt`  out  1  one-cycle grant pulse.
- `ls_valid`  out  1  one-cycle completion pulse.
- `ls_err`  out  1  qualifies `ls_valid`; misaligned access or illegal funct3.
- `ls_rdata`  out  32  extended load data, valid with `ls_valid`.
- `dbg_req`, `dbg_we`, `dbg_addr` (ADDR_W+2), `dbg_wdata` (32)  in  DBG request, word access only.
- `dbg_gnt`, `dbg_valid`, `dbg_err`, `dbg_rdata` (32)  out  same semantics as LSU.
- `mem_address`  out  ADDR_W  word address to `memory`.
- `mem_data_in`  out  32  lane-shifted write data.
- `mem_str`, `mem_ld`  out  1  store / load strobes.
- `mem_byte_masking`  out  4  byte enables.
- `mem_data_out`  in  32  read word; valid the cycle after `mem_ld` is asserted.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any request is pending, select a winner.
  - Default: LSU wins.
  - Pulse the winner's `*_gnt` combinationally in that cycle.
  - Latch the request and decode it.
  - Next state is ISSUE if the request is legal, otherwise RESP with error.
- **ISSUE:** drive the memory port for exactly one cycle.
  - `mem_address = addr[ADDR_W+1:2]`.
  - Store: `mem_str=1`. Load: `mem_ld=1`.
  - Next state: WAIT for loads, RESP for stores.
- **WAIT:** capture `mem_data_out`. For loads:
  - Shift right by `8*addr[1:0]`.
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
  - Next state: RESP.
- **RESP:** pulse `*_valid` (and `*_err` if applicable) with `*_rdata`. Next state: IDLE.
- **Byte mask:**
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << addr[1:0]`.
  - W and all DBG accesses: `4'b1111`.
  - Write data: `wdata << 8*addr[1:0]`.
- **Errors:** no memory strobe is issued; `*_rdata = 0`.
  - H/HU with `addr[0]=1`.
  - W with `addr[1:0]≠0`.
  - funct3 ∈ {011, 110, 111}.
  - Stores with funct3 ≥ 011.
  - DBG with `addr[1:0]≠0`.
- Requests arriving while not in IDLE wait; they are not dropped.

## Timing
- Grant in cycle 0 (IDLE):
  - Load: ISSUE c1, WAIT c2, `valid` c3; next grant no earlier than c4.
  - Store: ISSUE c1, `valid` c2; next grant no earlier than c3.
  - Error: `valid`+`err` c1.
- All outputs except `*_gnt` are registered.
- **Reset values:** state IDLE; all `*_gnt`, `*_valid`, `*_err`, `mem_str`, `mem_ld` = 0; `mem_address`, `mem_data_in`, `*_rdata` = 0; `mem_byte_masking = 4'b0000`; streak counter = 0.
- **Reset mid-operation:** the access is abandoned with no `valid`. A strobe asserted in the reset cycle is deasserted the following cycle.
- **Simultaneous `ls_req` and `dbg_req` in IDLE:** LSU wins unless the guard forces DBG (see Configuration).

## Configuration
- `DMEM_PORT_STARVE_GUARD_EN` defined:
  - A 4-bit streak counter increments on each LSU grant made while `dbg_req`=1.
  - When it reaches `MAX_STREAK`, the next IDLE arbitration grants DBG if `dbg_req`=1.
  - The counter clears on any DBG grant, or on an LSU grant made while `dbg_req`=0.
- Undefined: strict LSU priority. The counter logic is absent and DBG can starve.

## Test plan
- LSU SW at 0x004, `ls_wdata=0xDEADBEEF`, then LW at 0x004 → `mem_byte_masking=1111`, `mem_address=1` in c1; `ls_rdata=0xDEADBEEF` at c3.
- SB at 0x007 with 0x000000A5 → mask 1000, `mem_data_in=0xA5000000`. Then LB 0x007 → `0xFFFFFFA5`; LBU 0x007 → `0x000000A5`.
- LH at 0x003 → no `mem_ld`; `ls_valid`=`ls_err`=1 one cycle after grant; `ls_rdata=0`. Same for DBG at 0x002.
- `ls_req` and `dbg_req` held continuously:
  - Guard on, `MAX_STREAK`=4: grants LSU×4, DBG, LSU×4, …
  - Guard off: DBG is never granted.
- Assert `rst` in the WAIT cycle of a load → no `ls_valid`; all outputs 0 the next cycle; a new request after reset completes normally.
- LHU at 0x002 after SW 0x80017FFF at 0x000 → `0x00008001`; LH at 0x002 → `0xFFFF8001`.

Source files
------------

// File: rtl/dmem_port_ctrl.sv
// Arbitrates the LSU and a word-only debug port onto the single RV32I memory data port.
// Define DMEM_PORT_STARVE_GUARD_EN to bound consecutive LSU grants while DBG waits.
module dmem_port_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [2:0]          ls_funct3,
  input  logic [ADDR_W+1:0]   ls_addr,
  input  logic [31:0]         ls_wdata,
  output logic                ls_gnt,
  output logic                ls_valid,
  output logic                ls_err,
  output logic [31:0]         ls_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W+1:0]   dbg_addr,
  input  logic [31:0]         dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_valid,
  output logic                dbg_err,
  output logic [31:0]         dbg_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [31:0]         mem_data_in,
  output logic                mem_str,
  output logic                mem_ld,
  output logic [3:0]          mem_byte_masking,
  input  logic [31:0]         mem_data_out
);
  localparam int AW = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic              own_dbg_q, own_dbg_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_data_in_q, mem_data_in_d;
  logic              mem_str_q, mem_str_d, mem_ld_q, mem_ld_d;
  logic [3:0]        mask_q, mask_d;
  logic              ls_valid_q, ls_valid_d, ls_err_q, ls_err_d;
  logic              dbg_valid_q, dbg_valid_d, dbg_err_q, dbg_err_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d, dbg_rdata_q, dbg_rdata_d;

  logic              any_req, pick_dbg, force_dbg;
  logic              req_we, req_err;
  logic [2:0]        req_f3;
  logic [AW-1:0]     req_addr;
  logic [31:0]       req_wdata;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic acc_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: acc_err = we & f3[2];
      3'b001, 3'b101: acc_err = off[0] | (we & f3[2]);
      3'b010:         acc_err = (off != 2'b00);
      default:        acc_err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'h000000, sh[7:0]};
      3'b101:  load_ext = {16'h0000, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // DBG is decoded as a plain word access, so misalignment is its only error.
  always_comb begin
    any_req   = ls_req | dbg_req;
    pick_dbg  = dbg_req & (~ls_req | force_dbg);
    req_we    = pick_dbg ? dbg_we    : ls_we;
    req_f3    = pick_dbg ? 3'b010    : ls_funct3;
    req_addr  = pick_dbg ? dbg_addr  : ls_addr;
    req_wdata = pick_dbg ? dbg_wdata : ls_wdata;
    req_err   = acc_err(req_we, req_f3, req_addr[1:0]);
  end

`ifdef DMEM_PORT_STARVE_GUARD_EN
  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE && any_req) begin
      if (pick_dbg || !dbg_req) streak_d = 4'd0;
      else                      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= 4'd0;
    else     streak_q <= streak_d;
  end

  assign force_dbg = (streak_q >= 4'(MAX_STREAK));
`else
  assign force_dbg = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    own_dbg_d     = own_dbg_q;
    we_d          = we_q;
    f3_d          = f3_q;
    off_d         = off_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mask_d        = mask_q;
    mem_str_d     = 1'b0;
    mem_ld_d      = 1'b0;
    ls_valid_d    = 1'b0;
    ls_err_d      = 1'b0;
    dbg_valid_d   = 1'b0;
    dbg_err_d     = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    ls_gnt        = 1'b0;
    dbg_gnt       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ls_gnt    = ~pick_dbg;
          dbg_gnt   = pick_dbg;
          own_dbg_d = pick_dbg;
          we_d      = req_we;
          f3_d      = req_f3;
          off_d     = req_addr[1:0];
          if (req_err) begin
            state_d     = RESP;
            ls_valid_d  = ~pick_dbg;
            ls_err_d    = ~pick_dbg;
            dbg_valid_d = pick_dbg;
            dbg_err_d   = pick_dbg;
            if (pick_dbg) dbg_rdata_d = 32'd0;
            else          ls_rdata_d  = 32'd0;
          end else begin
            state_d       = ISSUE;
            mem_address_d = req_addr[AW-1:2];
            mem_data_in_d = req_wdata << {req_addr[1:0], 3'b000};
            mask_d        = lane_mask(req_f3, req_addr[1:0]);
            mem_str_d     = req_we;
            mem_ld_d      = ~req_we;
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        if (we_q) begin
          ls_valid_d  = ~own_dbg_q;
          dbg_valid_d = own_dbg_q;
          if (own_dbg_q) dbg_rdata_d = 32'd0;
          else           ls_rdata_d  = 32'd0;
        end
      end
      WAIT: begin
        state_d     = RESP;
        ls_valid_d  = ~own_dbg_q;
        dbg_valid_d = own_dbg_q;
        if (own_dbg_q) dbg_rdata_d = load_ext(f3_q, off_q, mem_data_out);
        else           ls_rdata_d  = load_ext(f3_q, off_q, mem_data_out);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_data_in_q <= 32'd0;
      mask_q        <= 4'b0000;
      mem_str_q     <= 1'b0;
      mem_ld_q      <= 1'b0;
      ls_valid_q    <= 1'b0;
      ls_err_q      <= 1'b0;
      dbg_valid_q   <= 1'b0;
      dbg_err_q     <= 1'b0;
      ls_rdata_q    <= 32'd0;
      dbg_rdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mask_q        <= mask_d;
      mem_str_q     <= mem_str_d;
      mem_ld_q      <= mem_ld_d;
      ls_valid_q    <= ls_valid_d;
      ls_err_q      <= ls_err_d;
      dbg_valid_q   <= dbg_valid_d;
      dbg_err_q     <= dbg_err_d;
      ls_rdata_q    <= ls_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

  // Request context only matters while a transaction is in flight.
  always_ff @(posedge clk) begin
    own_dbg_q <= own_dbg_d;
    we_q      <= we_d;
    f3_q      <= f3_d;
    off_q     <= off_d;
  end

  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_str          = mem_str_q;
  assign mem_ld           = mem_ld_q;
  assign mem_byte_masking = mask_q;
  assign ls_valid         = ls_valid_q;
  assign ls_err           = ls_err_q;
  assign ls_rdata         = ls_rdata_q;
  assign dbg_valid        = dbg_valid_q;
  assign dbg_err          = dbg_err_q;
  assign dbg_rdata        = dbg_rdata_q;

endmodule
